nv_arb_mux2: RTL and testbench
==============================

Name: nv_arb_mux2

Overview:
- Two-input valid/ready packet merger that arbitrates between two upstream streams and forwards one beat per cycle to a single downstream port.
- Its internal data-select path is a 2:1 select of in0_pd/in1_pd. The registered grant is also exported so external MUX2-based sideband paths can be steered in lockstep.
- It sits upstream of shared datapath consumers, for example a single SRAM write port or a single DMA request channel.
- Arbitration is round-robin at packet granularity. A multi-beat packet holds the grant until its last beat is accepted.

Parameters:
- DW, 32, payload width in bits for in0_pd, in1_pd and out_pd (minimum 1).

Ports:
- nvdla_core_clk  input  1  core clock; all state updates on the rising edge.
- nvdla_core_rst  input  1  asynchronous, active-high reset.
- in0_pvld  input  1  input 0 beat valid.
- in0_prdy  output  1  input 0 beat accepted this cycle.
- in0_pd  input  DW  input 0 payload.
- in0_last  input  1  input 0 beat is the last beat of its packet.
- in1_pvld  input  1  input 1 beat valid.
- in1_prdy  output  1  input 1 beat accepted this cycle.
- in1_pd  input  DW  input 1 payload.
- in1_last  input  1  input 1 beat is the last beat of its packet.
- out_pvld  output  1  output beat valid (registered).
- out_prdy  input  1  downstream ready.
- out_pd  output  DW  output payload (registered).
- out_last  output  1  output last flag (registered).
- out_src  output  1  source of the current output beat: 0 = in0, 1 = in1 (registered; drives external MUX2 select).

Behaviour:
- Single clock domain: nvdla_core_clk. Reset nvdla_core_rst is asynchronous and active-high.
- Reset values:
  - Outputs: out_pvld=0, out_pd=0, out_last=0, out_src=0.
  - Internal: lock=0, owner=0, rr_ptr=0 (input 0 wins the first tie).
- Output stage is a one-entry pipe register:
  - load_en = !out_pvld || out_prdy.
  - Latency from input acceptance to out_pvld is 1 cycle.
  - Full throughput: one beat per cycle while out_prdy stays high.
- Grant (combinational, evaluated every cycle):
  - lock=1: grant=owner. The other input is never granted, even if the owner is not valid.
  - lock=0, exactly one input valid: grant goes to that input.
  - lock=0, both inputs valid: grant=rr_ptr.
  - lock=0, neither input valid: no grant.
- Ready generation:
  - in0_prdy = load_en && grant==0 && (lock || in0_pvld).
  - in1_prdy is the same with grant==1.
  - Both readys are never high in the same cycle.
  - Neither ready depends on its own input's pvld when lock=1 (no combinational valid→ready loop on the locked port).
- Accept (beat from input g with load_en):
  - Capture {pd, last, g} into the output register.
  - Set out_pvld=1.
- load_en with no accept: out_pvld goes to 0; pd, last and src hold their values.
- Lock state machine, two states:
  - UNLOCKED → LOCKED(owner=g) on accepting a beat with last=0.
  - LOCKED → UNLOCKED on accepting the owner's beat with last=1. On this transition rr_ptr = !owner.
  - Single-beat packet (last=1 while UNLOCKED): stay UNLOCKED and set rr_ptr = !g.
- Backpressure:
  - While out_pvld=1 and out_prdy=0, all output registers hold and both prdy outputs are 0.
  - Input payloads are not sampled until the input is accepted.
- Starvation bound: after at most one packet from the other input, a waiting input is granted.
- Reset mid-packet: lock is cleared, the output is dropped, and arbitration restarts with rr_ptr=0. Upstream owns resynchronizing its packet.

Optional Feature:
- Macro: NV_ARB_MUX2_STRICT_PRIO_EN.
- Defined:
  - In the unlocked state input 0 always wins when both inputs are valid; rr_ptr is removed.
  - Packet locking is unchanged, so an in-flight in1 packet still completes before in0 wins.
  - The starvation bound does not hold for in1.
- Undefined: round-robin behaviour exactly as in Behaviour.

Test Plan:
- Single beats:
  - Stimulus: reset, then in0 sends 0xA0 with last=1; out_prdy=1.
  - Response: in0_prdy=1 in cycle 0; next cycle out_pvld=1, out_pd=0xA0, out_last=1, out_src=0.
- Round-robin tie:
  - Stimulus: both inputs hold single-beat packets (in0 0x10/0x11, in1 0x20/0x21), out_prdy=1.
  - Response: output order is 0x10, 0x20, 0x11, 0x21; out_src toggles 0,1,0,1.
- Packet lock:
  - Stimulus: in1 sends a 3-beat packet 0x30, 0x31, 0x32(last). in0 becomes valid with 0x40 after the first in1 beat.
  - Response: output is 0x30, 0x31, 0x32, then 0x40; in0_prdy stays 0 until 0x32 is accepted.
- Backpressure:
  - Stimulus: out_prdy=0 for 4 cycles with both inputs valid.
  - Response: out_pd stays at its first captured value; in0_prdy=in1_prdy=0 during the stall; no beat is lost or duplicated after out_prdy=1.
- Reset mid-packet:
  - Stimulus: in0 sends 2 of 4 beats, then nvdla_core_rst is asserted asynchronously.
  - Response: out_pvld=0 immediately. After release, with both inputs valid, in0 is granted first (rr_ptr=0).
- Strict priority (NV_ARB_MUX2_STRICT_PRIO_EN defined):
  - Stimulus: both inputs continuously valid with single-beat packets.
  - Response: in1_prdy never asserts; every output beat has out_src=0.

Source files
------------

// File: rtl/nv_arb_mux2.sv
// nv_arb_mux2: two-input packet-granular round-robin valid/ready merger with registered output stage and exported grant (out_src); ports nvdla_core_clk/nvdla_core_rst, in0_*/in1_* upstream (pvld, prdy, pd, last), out_* downstream (pvld, prdy, pd, last, src); define NV_ARB_MUX2_STRICT_PRIO_EN for fixed in0 priority
module nv_arb_mux2 #(
  parameter int DW = 32
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rst,
  input  logic          in0_pvld,
  output logic          in0_prdy,
  input  logic [DW-1:0] in0_pd,
  input  logic          in0_last,
  input  logic          in1_pvld,
  output logic          in1_prdy,
  input  logic [DW-1:0] in1_pd,
  input  logic          in1_last,
  output logic          out_pvld,
  input  logic          out_prdy,
  output logic [DW-1:0] out_pd,
  output logic          out_last,
  output logic          out_src
);
  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;
  logic [0:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          out_pvld_q, out_pvld_d;
  logic [DW-1:0] out_pd_q, out_pd_d;
  logic          out_last_q, out_last_d;
  logic          out_src_q, out_src_d;
  logic          locked, load_en, tie_gnt, gnt, acc, acc_last;
`ifdef NV_ARB_MUX2_STRICT_PRIO_EN
  assign tie_gnt = 1'b0;
`else
  logic rr_q, rr_d;
  assign tie_gnt = rr_q;
`endif
  assign locked   = state_q == ST_LOCKED;
  assign load_en  = !out_pvld_q || out_prdy;
  // with neither input valid gnt is 0, but in0_prdy stays low because in0_pvld is low
  assign gnt      = locked ? owner_q : (in0_pvld && in1_pvld) ? tie_gnt : in1_pvld;
  // the locked port's ready ignores its own valid so there is no valid->ready loop
  assign in0_prdy = load_en && !gnt && (locked || in0_pvld);
  assign in1_prdy = load_en && gnt && (locked || in1_pvld);
  assign acc      = (in0_prdy && in0_pvld) || (in1_prdy && in1_pvld);
  assign acc_last = gnt ? in1_last : in0_last;
  always_comb begin
    state_d    = acc ? (acc_last ? ST_UNLOCKED : ST_LOCKED) : state_q;
    owner_d    = (acc && !acc_last) ? gnt : owner_q;
    out_pvld_d = load_en ? acc : out_pvld_q;
    out_pd_d   = acc ? (gnt ? in1_pd : in0_pd) : out_pd_q;
    out_last_d = acc ? acc_last : out_last_q;
    out_src_d  = acc ? gnt : out_src_q;
  end
`ifndef NV_ARB_MUX2_STRICT_PRIO_EN
  // gnt equals owner while locked, so !gnt covers both packet-end cases
  assign rr_d = (acc && acc_last) ? !gnt : rr_q;
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst)
    if (nvdla_core_rst) rr_q <= 1'b0;
    else rr_q <= rr_d;
`endif
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q    <= ST_UNLOCKED;
      owner_q    <= 1'b0;
      out_pvld_q <= 1'b0;
      out_pd_q   <= '0;
      out_last_q <= 1'b0;
      out_src_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      out_pvld_q <= out_pvld_d;
      out_pd_q   <= out_pd_d;
      out_last_q <= out_last_d;
      out_src_q  <= out_src_d;
    end
  end
  assign out_pvld = out_pvld_q;
  assign out_pd   = out_pd_q;
  assign out_last = out_last_q;
  assign out_src  = out_src_q;
endmodule

// File: tb/tb_nv_arb_mux2.sv
// tb_nv_arb_mux2: directed stimulus with a packet-level reference model and hand-computed expectations
module tb_nv_arb_mux2;
  localparam int DW = 32;
`ifdef NV_ARB_MUX2_STRICT_PRIO_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif
  typedef struct {
    logic [DW-1:0] pd;
    logic          last;
  } beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in0_pvld = 1'b0, in0_prdy, in0_last = 1'b0;
  logic in1_pvld = 1'b0, in1_prdy, in1_last = 1'b0;
  logic [DW-1:0] in0_pd = '0, in1_pd = '0, out_pd;
  logic out_pvld, out_prdy = 1'b1, out_last, out_src;
  always #5 clk = ~clk;
  nv_arb_mux2 #(.DW(DW)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst),
    .in0_pvld(in0_pvld), .in0_prdy(in0_prdy), .in0_pd(in0_pd), .in0_last(in0_last),
    .in1_pvld(in1_pvld), .in1_prdy(in1_prdy), .in1_pd(in1_pd), .in1_last(in1_last),
    .out_pvld(out_pvld), .out_prdy(out_prdy), .out_pd(out_pd), .out_last(out_last),
    .out_src(out_src)
  );
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  beat_t q0[$], q1[$];
  logic [DW-1:0] got[$];
  logic gsrc[$];
  // reference model: which input owns an open packet (-1 none), who wins the next tie, output slot
  int m_owner = -1;
  int m_tie = 0;
  int who;
  bit room, take;
  logic m_vld = 1'b0, m_last = 1'b0, m_src = 1'b0;
  logic [DW-1:0] m_pd = '0;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_pvld", out_pvld, 0);
      chk("rst_pd", out_pd, 0);
      chk("rst_last", out_last, 0);
      chk("rst_src", out_src, 0);
      m_owner = -1; m_tie = 0; m_vld = 0; m_pd = '0; m_last = 0; m_src = 0;
    end else begin
      chk("m_pvld", out_pvld, m_vld);
      chk("m_pd", out_pd, m_pd);
      chk("m_last", out_last, m_last);
      chk("m_src", out_src, m_src);
      if (out_pvld && out_prdy) begin
        got.push_back(out_pd);
        gsrc.push_back(out_src);
      end
      room = !m_vld || out_prdy;
      if (m_owner >= 0) who = m_owner;
      else if (in0_pvld && in1_pvld) who = STRICT ? 0 : m_tie;
      else if (in0_pvld) who = 0;
      else if (in1_pvld) who = 1;
      else who = -1;
      chk("m_in0_prdy", in0_prdy, room && who == 0);
      chk("m_in1_prdy", in1_prdy, room && who == 1);
      take = room && ((who == 0 && in0_pvld) || (who == 1 && in1_pvld));
      if (room) m_vld = take;
      if (take) begin
        m_pd   = who == 1 ? in1_pd : in0_pd;
        m_last = who == 1 ? in1_last : in0_last;
        m_src  = who == 1;
        if (m_last) begin
          m_owner = -1;
          m_tie = 1 - who;
        end else m_owner = who;
      end
    end
  end
  task automatic drive();
    in0_pvld = q0.size() > 0;
    in1_pvld = q1.size() > 0;
    in0_pd = '0; in0_last = 0; in1_pd = '0; in1_last = 0;
    if (in0_pvld) begin in0_pd = q0[0].pd; in0_last = q0[0].last; end
    if (in1_pvld) begin in1_pd = q1[0].pd; in1_last = q1[0].last; end
  endtask
  task automatic step();
    bit a0, a1;
    @(negedge clk);
    a0 = in0_pvld && in0_prdy;
    a1 = in1_pvld && in1_prdy;
    @(posedge clk);
    #1;
    if (a0) void'(q0.pop_front());
    if (a1) void'(q1.pop_front());
    drive();
  endtask
  task automatic do_reset();
    q0.delete(); q1.delete();
    out_prdy = 1'b1;
    drive();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    got.delete(); gsrc.delete();
  endtask
  task automatic seq_chk(input string name, input logic [DW-1:0] e0, e1, e2, e3);
    logic [DW-1:0] e [4];
    e = '{e0, e1, e2, e3};
    chk({name, "_count"}, got.size(), 4);
    for (int i = 0; i < 4; i++) chk(name, i < got.size() ? got[i] : '1, e[i]);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    do_reset();
    chk("reset_out_pvld", out_pvld, 0);
    q0.push_back('{32'hA0, 1'b1});
    drive();
    #1 chk("single_in0_prdy", in0_prdy, 1);
    step();
    chk("single_pvld", out_pvld, 1);
    chk("single_pd", out_pd, 32'hA0);
    chk("single_last", out_last, 1);
    chk("single_src", out_src, 0);
    step();
    do_reset();
    q0.push_back('{32'h10, 1'b1}); q0.push_back('{32'h11, 1'b1});
    q1.push_back('{32'h20, 1'b1}); q1.push_back('{32'h21, 1'b1});
    drive();
    repeat (6) step();
    seq_chk("tie", 32'h10, STRICT ? 32'h11 : 32'h20, STRICT ? 32'h20 : 32'h11, 32'h21);
    for (int i = 0; i < 4; i++)
      chk("tie_src", i < gsrc.size() ? gsrc[i] : 1'bx, STRICT ? (i >= 2) : (i % 2 == 1));
    do_reset();
    q1.push_back('{32'h30, 1'b0}); q1.push_back('{32'h31, 1'b0}); q1.push_back('{32'h32, 1'b1});
    drive();
    step();
    q0.push_back('{32'h40, 1'b1});
    drive();
    #1 chk("lock_in0_blocked", in0_prdy, 0);
    repeat (6) step();
    seq_chk("lock", 32'h30, 32'h31, 32'h32, 32'h40);
    do_reset();
    q0.push_back('{32'h50, 1'b1}); q0.push_back('{32'h51, 1'b1});
    q1.push_back('{32'h60, 1'b1}); q1.push_back('{32'h61, 1'b1});
    drive();
    step();
    out_prdy = 1'b0;
    repeat (4) begin
      #1;
      chk("bp_pd", out_pd, 32'h50);
      chk("bp_in0_prdy", in0_prdy, 0);
      chk("bp_in1_prdy", in1_prdy, 0);
      step();
    end
    out_prdy = 1'b1;
    repeat (6) step();
    seq_chk("bp", 32'h50, STRICT ? 32'h51 : 32'h60, STRICT ? 32'h60 : 32'h51, 32'h61);
    do_reset();
    q0.push_back('{32'h70, 1'b0}); q0.push_back('{32'h71, 1'b0});
    q0.push_back('{32'h72, 1'b0}); q0.push_back('{32'h73, 1'b1});
    drive();
    step();
    step();
    #2 rst = 1'b1;
    #1 chk("rst_async_pvld", out_pvld, 0);
    q0.delete();
    drive();
    @(posedge clk);
    #1 rst = 1'b0;
    got.delete(); gsrc.delete();
    q0.push_back('{32'h80, 1'b1});
    q1.push_back('{32'h90, 1'b1});
    drive();
    #1;
    chk("rst_in0_first", in0_prdy, 1);
    chk("rst_in1_wait", in1_prdy, 0);
    repeat (4) step();
    chk("rst_first_beat", got.size() > 0 ? got[0] : '1, 32'h80);
    chk("rst_second_beat", got.size() > 1 ? got[1] : '1, 32'h90);
    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
